// File: rtl/vram_pkg.sv
// Shared types and defaults for the VRAM write port.
// Provides widths, window base, FSM states and the buffered store record.
package vram_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam logic [31:0] VRAM_BASE = 32'h0001_0000;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD
    } vram_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } vram_req_t;

endpackage

// File: rtl/vram_write_port_if.sv
// Bus bundle between processor, video controller and the VRAM write side.
// master: drives stores and blank_n; slave: the write port (drives vram_* and status).
interface vram_write_port_if
    import vram_pkg::*;
();

    logic              mem_write;
    logic [31:0]       data_adr;
    logic [DATA_W-1:0] write_data;
    logic              blank_n;
    logic              vram_we;
    logic [ADDR_W-1:0] vram_addr;
    logic [DATA_W-1:0] vram_wdata;
    logic              pending;
    logic              overflow;
    logic [7:0]        drop_cnt;

    modport master (
        output mem_write,
        output data_adr,
        output write_data,
        output blank_n,
        input  vram_we,
        input  vram_addr,
        input  vram_wdata,
        input  pending,
        input  overflow,
        input  drop_cnt
    );

    modport slave (
        input  mem_write,
        input  data_adr,
        input  write_data,
        input  blank_n,
        output vram_we,
        output vram_addr,
        output vram_wdata,
        output pending,
        output overflow,
        output drop_cnt
    );

endinterface

// File: rtl/vram_write_port_fifo.sv
// sync_fifo: store buffer for the VRAM write port, generic entry type.
// Ports: clk, rst_n, push/din, pop/dout, full, empty. Caller never overfills/underflows.
module sync_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    T mem [DEPTH];

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end

    assign dout  = mem[rptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/vram_write_port.sv
// Buffers processor stores hitting the frame-buffer window; commits them to VRAM.
// Ports: clk, reset (async, active-low), bus (slave). Macro: VRAM_WRITE_ANYTIME_EN.
module vram_write_port
    import vram_pkg::*;
#(
    parameter int VRAM_WORDS = 65536,
    parameter int FIFO_DEPTH = 4
) (
    input logic               clk,
    input logic               reset,
    vram_write_port_if.slave  bus
);

    localparam logic [32:0] WIN_LO = {1'b0, VRAM_BASE};
    localparam logic [32:0] WIN_HI =
        WIN_LO + 33'(VRAM_WORDS) * 33'd4;

    vram_state_t state;
    vram_state_t state_nx;

    vram_req_t   head;
    vram_req_t   req;
    logic        full;
    logic        empty;
    logic        pop;
    logic        push;
    logic        drop;
    logic        hit;
    logic        win_open;
    logic        drain;
    logic [31:0] off;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              ovf_q;
    logic [7:0]        drop_q;

`ifdef VRAM_WRITE_ANYTIME_EN
    // True dual-port VRAM: no need to wait for blanking.
    assign win_open = 1'b1;
`else
    assign win_open = !bus.blank_n;
`endif

    assign hit = bus.mem_write
              && ({1'b0, bus.data_adr} >= WIN_LO)
              && ({1'b0, bus.data_adr} <  WIN_HI);

    assign off      = bus.data_adr - VRAM_BASE;
    assign req.addr = ADDR_W'(off >> 2);
    assign req.data = bus.write_data;

    // A full FIFO still accepts when the head leaves this cycle.
    assign push  = hit && (!full || pop);
    assign drop  = hit && full && !pop;
    assign drain = !empty && win_open;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (vram_req_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (push),
        .din   (req),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (drain) state_nx = ISSUE;
            end
            ISSUE: begin
                pop      = 1'b1;
                state_nx = HOLD;
            end
            HOLD: begin
                state_nx = drain ? ISSUE : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            addr_q <= '0;
            data_q <= '0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            state <= state_nx;
            if (state == ISSUE) begin
                addr_q <= head.addr;
                data_q <= head.data;
            end
            if (drop) begin
                ovf_q <= 1'b1;
                if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
            end
        end
    end

    // Decoded from state so an async reset drops it at once.
    assign bus.vram_we    = (state == HOLD);
    assign bus.vram_addr  = addr_q;
    assign bus.vram_wdata = data_q;
    assign bus.pending    = !empty || (state != IDLE);
    assign bus.overflow   = ovf_q;
    assign bus.drop_cnt   = drop_q;

endmodule

// File: tb/tb_vram_write_port.sv
// Self-checking bench for vram_write_port: decode table, ordered drain,
// overflow, async reset in HOLD, drop saturation, randomized episodes.
module tb_vram_write_port;
    import vram_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    vram_write_port_if bus ();

    vram_write_port #(
        .VRAM_WORDS (65536),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    logic [47:0] wq [$];
    int          wt [$];

    typedef struct {
        logic [31:0] adr;
        logic [31:0] data;
        bit          exp_we;
        logic [15:0] exp_addr;
    } vec_t;

    vec_t tbl [8];

    task automatic check(string name, logic [63:0] act,
                         logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (bus.vram_we === 1'b1) begin
            wq.push_back({bus.vram_addr, bus.vram_wdata});
            wt.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic store(logic [31:0] adr, logic [31:0] d);
        bus.mem_write  = 1'b1;
        bus.data_adr   = adr;
        bus.write_data = d;
        step();
        bus.mem_write  = 1'b0;
    endtask

    task automatic do_reset();
        bus.mem_write = 1'b0;
        bus.blank_n   = 1'b1;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        wq.delete();
        wt.delete();
    endtask

    function automatic bit is_hit(logic [31:0] a);
        return (a >= 32'h0001_0000) && (a < 32'h0005_0000);
    endfunction

    function automatic logic [15:0] idx_of(logic [31:0] a);
        logic [31:0] w;
        w = (a - 32'h0001_0000) / 4;
        return w[15:0];
    endfunction

    initial begin
        logic [31:0] d [6];
        logic [47:0] mq [$];
        int drop_m;
        bit ovf_m;
        int n;

        tbl[0] = '{32'h0001_0008, 32'hDEAD_BEEF, 1'b1, 16'h0002};
        tbl[1] = '{32'h0001_0000, 32'h1111_1111, 1'b1, 16'h0000};
        tbl[2] = '{32'h0001_000B, 32'h2222_2222, 1'b1, 16'h0002};
        tbl[3] = '{32'h0004_FFFC, 32'h3333_3333, 1'b1, 16'hFFFF};
        tbl[4] = '{32'h0005_0000, 32'h4444_4444, 1'b0, 16'h0000};
        tbl[5] = '{32'h0000_FFFC, 32'h5555_5555, 1'b0, 16'h0000};
        tbl[6] = '{32'hFFFF_FFFC, 32'h6666_6666, 1'b0, 16'h0000};
        tbl[7] = '{32'h0001_2344, 32'h7777_7777, 1'b1, 16'h08D1};

        rst_n          = 1'b0;
        bus.mem_write  = 1'b0;
        bus.data_adr   = '0;
        bus.write_data = '0;
        bus.blank_n    = 1'b1;
        step();
        step();
        check("rst_we", 64'(bus.vram_we), 64'd0);
        check("rst_addr", 64'(bus.vram_addr), 64'd0);
        check("rst_wdata", 64'(bus.vram_wdata), 64'd0);
        check("rst_pending", 64'(bus.pending), 64'd0);
        check("rst_ovf", 64'(bus.overflow), 64'd0);
        check("rst_drop", 64'(bus.drop_cnt), 64'd0);
        rst_n = 1'b1;
        step();

        // Decode table with the window open.
        bus.blank_n = 1'b0;
        foreach (tbl[i]) begin
            wq.delete();
            store(tbl[i].adr, tbl[i].data);
            step();
            step();
            check($sformatf("tbl%0d_we", i),
                  64'(wq.size()), 64'(tbl[i].exp_we));
            if (tbl[i].exp_we && wq.size() == 1) begin
                check($sformatf("tbl%0d_addr", i),
                      64'(wq[0][47:32]), 64'(tbl[i].exp_addr));
                check($sformatf("tbl%0d_data", i),
                      64'(wq[0][31:0]), 64'(tbl[i].data));
            end
            step();
            check($sformatf("tbl%0d_pend", i),
                  64'(bus.pending), 64'd0);
        end

`ifdef VRAM_WRITE_ANYTIME_EN
        do_reset();
        bus.blank_n = 1'b1;
        store(32'h0001_0010, 32'hA5A5_0001);
        step();
        step();
        check("any_we", 64'(wq.size()), 64'd1);
        if (wq.size() == 1)
            check("any_addr", 64'(wq[0][47:32]), 64'd4);
        step();
`else
        // Closed window holds stores; opening drains in order.
        do_reset();
        for (int i = 0; i < 3; i++) d[i] = $urandom;
        for (int i = 0; i < 3; i++)
            store(32'h0001_0000 + 32'(4*i), d[i]);
        step();
        step();
        step();
        check("hold_nowe", 64'(wq.size()), 64'd0);
        check("hold_pend", 64'(bus.pending), 64'd1);
        bus.blank_n = 1'b0;
        for (int k = 0; k < 20 && wq.size() < 3; k++) step();
        check("drain_cnt", 64'(wq.size()), 64'd3);
        if (wq.size() == 3) begin
            for (int i = 0; i < 3; i++)
                check($sformatf("drain%0d", i), 64'(wq[i]),
                      64'({16'(i), d[i]}));
            check("space01", 64'(wt[1] - wt[0]), 64'd2);
            check("space12", 64'(wt[2] - wt[1]), 64'd2);
        end
        step();
        check("drain_pend", 64'(bus.pending), 64'd0);

        // Six stores into a four-deep buffer.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            d[i] = $urandom;
            store(32'h0001_0028 + 32'(4*i), d[i]);
        end
        step();
        check("ovf_flag", 64'(bus.overflow), 64'd1);
        check("ovf_drop", 64'(bus.drop_cnt), 64'd2);
        bus.blank_n = 1'b0;
        for (int k = 0; k < 16; k++) step();
        check("ovf_cnt", 64'(wq.size()), 64'd4);
        if (wq.size() == 4)
            for (int i = 0; i < 4; i++)
                check($sformatf("ovf_w%0d", i), 64'(wq[i]),
                      64'({16'(10 + i), d[i]}));
        check("ovf_sticky", 64'(bus.overflow), 64'd1);
`endif

        // Async reset while a write is in HOLD.
        bus.blank_n = 1'b0;
        wq.delete();
        store(32'h0001_0050, 32'hCAFE_0000);
        store(32'h0001_0054, 32'hCAFE_0001);
        store(32'h0001_0058, 32'hCAFE_0002);
        for (int k = 0; k < 10 && wq.size() == 0; k++) step();
        check("hrst_pre_we", 64'(bus.vram_we), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("hrst_we", 64'(bus.vram_we), 64'd0);
        check("hrst_addr", 64'(bus.vram_addr), 64'd0);
        check("hrst_wdata", 64'(bus.vram_wdata), 64'd0);
        check("hrst_pend", 64'(bus.pending), 64'd0);
        check("hrst_ovf", 64'(bus.overflow), 64'd0);
        check("hrst_drop", 64'(bus.drop_cnt), 64'd0);
        step();
        rst_n = 1'b1;
        wq.delete();
        for (int k = 0; k < 8; k++) step();
        check("hrst_empty", 64'(wq.size()), 64'd0);
        check("hrst_idle", 64'(bus.pending), 64'd0);

`ifndef VRAM_WRITE_ANYTIME_EN
        // Drop counter saturates at 255.
        do_reset();
        bus.mem_write  = 1'b1;
        bus.data_adr   = 32'h0001_0100;
        bus.write_data = 32'h0BAD_F00D;
        for (int k = 0; k < DEPTH + 260; k++) step();
        bus.mem_write = 1'b0;
        step();
        check("sat_drop", 64'(bus.drop_cnt), 64'd255);
        check("sat_ovf", 64'(bus.overflow), 64'd1);

        // Randomized episodes against a queue model.
        do_reset();
        drop_m = 0;
        ovf_m  = 1'b0;
        for (int ep = 0; ep < 30; ep++) begin
            bus.blank_n = 1'b1;
            step();
            step();
            step();
            wq.delete();
            mq.delete();
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) begin
                logic [31:0] a;
                logic [31:0] v;
                bit mw;
                int kind;
                mw   = ($urandom % 4) != 0;
                kind = $urandom % 4;
                v    = $urandom;
                if (kind == 0)
                    a = $urandom_range(0, 32'h0000_FFFF);
                else if (kind == 1)
                    a = 32'h0005_0000 + $urandom_range(0, 32'h00FF_FFFF);
                else
                    a = 32'h0001_0000 + $urandom_range(0, 32'h0003_FFFF);
                bus.mem_write  = mw;
                bus.data_adr   = a;
                bus.write_data = v;
                step();
                if (mw && is_hit(a)) begin
                    if (mq.size() < DEPTH) begin
                        mq.push_back({idx_of(a), v});
                    end else begin
                        ovf_m = 1'b1;
                        if (drop_m < 255) drop_m++;
                    end
                end
            end
            bus.mem_write = 1'b0;
            step();
            check($sformatf("ep%0d_closed", ep),
                  64'(wq.size()), 64'd0);
            check($sformatf("ep%0d_drop", ep),
                  64'(bus.drop_cnt), 64'(drop_m));
            check($sformatf("ep%0d_ovf", ep),
                  64'(bus.overflow), 64'(ovf_m));
            check($sformatf("ep%0d_pend", ep),
                  64'(bus.pending), 64'(mq.size() != 0));
            bus.blank_n = 1'b0;
            for (int k = 0; k < 14; k++) step();
            check($sformatf("ep%0d_cnt", ep),
                  64'(wq.size()), 64'(mq.size()));
            if (wq.size() == mq.size())
                foreach (mq[i])
                    check($sformatf("ep%0d_w%0d", ep, i),
                          64'(wq[i]), 64'(mq[i]));
            check($sformatf("ep%0d_done", ep),
                  64'(bus.pending), 64'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
